mem_byte_seq: RTL and testbench
===============================

// Module: mem_byte_seq
// PURPOSE
//  Byte-serial load/store sequencer between the Hunter_RV32 core and the 8-bit data memory.
//  Splits one LB/LH/LW/SB/SH/SW request into 1/2/4 byte accesses and drives lane_sel to the
//  downstream 4:1 byte mux, which picks the store byte from st_data. Assembles returned load
//  bytes little-endian, then sign- or zero-extends them into a 32-bit response.
// PARAMETERS
//  AW   32  memory address width
// PORTS
//  clk           in   1   clock, rising edge
//  rst_n         in   1   asynchronous active-low reset
//  req_valid     in   1   request strobe; accepted when req_valid & req_ready
//  req_ready     out  1   high only in IDLE
//  req_we        in   1   1 = store, 0 = load
//  req_size      in   2   00 byte, 01 half, 10 word, 11 reserved
//  req_unsigned  in   1   1 = zero-extend load (LBU/LHU)
//  req_addr      in   AW  byte address
//  req_wdata     in   32  store data; byte k in bits [8k+7:8k]
//  st_data       out  32  registered req_wdata; feeds the 4:1 byte mux inputs
//  lane_sel      out  2   byte index k of the current access; feeds the 4:1 byte mux sel
//  mem_en        out  1   memory access strobe
//  mem_we        out  1   memory write enable; the byte comes from the 4:1 byte mux
//  mem_addr      out  AW  req_addr + lane_sel, modulo 2^AW
//  mem_rdata     in   8   read byte, valid the cycle after mem_en & !mem_we
//  resp_valid    out  1   one-cycle completion pulse
//  resp_rdata    out  32  extended load data; 0 for stores
//  resp_err      out  1   misaligned/reserved access (MISALIGN_TRAP_EN only, else 0)
// BEHAVIOUR
//  - Reset is asynchronous. All outputs are 0 and state is IDLE; req_ready rises once rst_n is released.
//  - FSM states:
//    IDLE: req_ready=1. On acceptance, latch we/size/unsigned/addr/wdata, set idx=0, set
//      N = 1/2/4 bytes (reserved size 11 = word), then go to XFER.
//    XFER: mem_en=1, mem_we=we, lane_sel=idx, mem_addr=addr+idx.
//      idx increments each cycle. After byte N-1: store -> DONE; load -> LAST.
//    LAST: mem_en=0. Capture the final read byte, then go to DONE.
//    DONE: resp_valid=1 for 1 cycle, then return to IDLE. No request is accepted in DONE.
//  - Load capture: the byte returned for idx k is written to buf[8k+7:8k] the next cycle;
//    this write overlaps XFER of idx k+1.
//  - Extension: byte uses buf[7:0] with bit 7 as sign; half uses buf[15:0] with bit 15 as sign;
//    word is buf as-is. req_unsigned forces zero fill.
//  - Latency from acceptance to resp_valid: store N+1 cycles; load N+2 cycles.
//  - Control outputs mem_en, mem_we, lane_sel, mem_addr, req_ready and resp_valid decode from
//    the state/idx registers only; there is no combinational path from inputs.
//  - Address wrap: addr+idx wraps at 2^AW silently.
//  - req_valid outside IDLE is ignored. The requester holds it until req_ready.
//  - An async reset mid-request drops mem_en at once; the partial store is not rolled back.
// CONFIGURATION
//  - MISALIGN_TRAP_EN defined: a half with addr[0]=1, a word with addr[1:0]!=0, or size 11
//    skips XFER/LAST. The block goes IDLE->DONE with resp_err=1 and resp_rdata=0, and issues no mem_en.
//  - MISALIGN_TRAP_EN undefined: misaligned accesses run byte-serially as normal; resp_err is tied to 0.
// STRUCTURE
//  - Package hunter_lsu_pkg: SIZE_B/SIZE_H/SIZE_W encodings, FSM state localparams
//    (IDLE, XFER, LAST, DONE), size-to-byte-count function.
//  - Sub-module ld_extend: combinational 32-bit sign/zero extender (buf, size, unsigned -> rdata).
//  - The 4:1 byte mux is instantiated by the parent, outside this block.
// TESTING
//  1. SW addr 0x100, wdata 0xA1B2C3D4 -> lane_sel 0,1,2,3 at mem_addr 0x100..0x103 with mem_we=1;
//     resp_valid on cycle 5 after acceptance.
//  2. LB addr 0x203, mem byte 0x80 -> resp_rdata 0xFFFFFF80; LBU of the same byte -> 0x00000080.
//  3. LH addr 0x10, bytes 0x34,0x92 -> resp_rdata 0xFFFF9234, resp_valid 4 cycles after acceptance.
//  4. LW addr 0x2 with MISALIGN_TRAP_EN -> no mem_en, resp_err=1, resp_rdata=0. Without the macro
//     -> 4 reads at 0x2..0x5, resp_err=0.
//  5. Deassert rst_n during idx 1 of an SW -> mem_en=0 immediately; after release req_ready=1, state IDLE.
//  6. SB at addr 0xFFFFFFFF, followed back-to-back by a new req_valid -> mem_addr 0xFFFFFFFF;
//     the second request is accepted only in the cycle after resp_valid.

Source files
------------

// File: rtl/hunter_lsu_pkg.sv
// Shared encodings for the Hunter_RV32 byte-serial load/store path:
// access sizes, sequencer states and the size-to-byte-count helper.
package hunter_lsu_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    XFER = 2'b01,
    LAST = 2'b10,
    DONE = 2'b11
  } state_t;

  // Reserved size 11 falls through to the word count.
  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_B:  return 3'd1;
      SIZE_H:  return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    case (size)
      SIZE_B:  return 1'b0;
      SIZE_H:  return addr_lo[0];
      SIZE_W:  return addr_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/ld_extend.sv
// Combinational sign/zero extender for assembled load data
// (byte and half take their sign from bit 7 / bit 15, word passes through).
module ld_extend
  import hunter_lsu_pkg::*;
(
  input  logic [31:0] data_in,
  input  logic [1:0]  size,
  input  logic        zext,
  output logic [31:0] rdata
);

  always_comb begin
    rdata = data_in;
    case (size)
      SIZE_B:  rdata = {{24{~zext & data_in[7]}}, data_in[7:0]};
      SIZE_H:  rdata = {{16{~zext & data_in[15]}}, data_in[15:0]};
      default: rdata = data_in;
    endcase
  end

endmodule

// File: rtl/mem_byte_seq.sv
// Byte-serial load/store sequencer between the core and the 8-bit data memory.
// Optional feature: define MISALIGN_TRAP_EN to trap misaligned/reserved accesses.
module mem_byte_seq
  import hunter_lsu_pkg::*;
#(
  parameter int AW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic [31:0]   st_data,
  output logic [1:0]    lane_sel,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  input  logic [7:0]    mem_rdata,
  output logic          resp_valid,
  output logic [31:0]   resp_rdata,
  output logic          resp_err
);

  state_t        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [1:0]    last_q;
  logic          we_q;
  logic [1:0]    size_q;
  logic          zext_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   data_buf;
  logic          cap_en_q;
  logic [1:0]    cap_idx_q;
  logic [31:0]   ext_data;
  logic          accept;
`ifdef MISALIGN_TRAP_EN
  logic          err_q;
`endif

  assign accept = req_valid && (state_q == IDLE);

  // Next-state logic; idx walks 0..last_q while the byte accesses are issued.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = 2'd0;
          state_d = XFER;
`ifdef MISALIGN_TRAP_EN
          if (is_misaligned(req_size, req_addr[1:0])) state_d = DONE;
`endif
        end
      end
      XFER: begin
        if (idx_q == last_q) state_d = we_q ? DONE : LAST;
        else                 idx_d   = idx_q + 2'd1;
      end
      LAST:    state_d = DONE;
      default: state_d = IDLE;
    endcase
  end

  // Memory-side and handshake outputs decode only from registered state.
  always_comb begin
    req_ready  = rst_n && (state_q == IDLE);
    mem_en     = (state_q == XFER);
    mem_we     = (state_q == XFER) && we_q;
    lane_sel   = (state_q == XFER) ? idx_q : 2'd0;
    mem_addr   = (state_q == XFER) ? addr_q + AW'(idx_q) : '0;
    resp_valid = (state_q == DONE);
    resp_rdata = (state_q == DONE && !we_q) ? ext_data : 32'd0;
`ifdef MISALIGN_TRAP_EN
    resp_err   = (state_q == DONE) && err_q;
    if (err_q) resp_rdata = 32'd0;
`else
    resp_err   = 1'b0;
`endif
  end

  // Read byte k lands one cycle after its access, overlapping access k+1 or LAST.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      idx_q     <= 2'd0;
      last_q    <= 2'd0;
      we_q      <= 1'b0;
      size_q    <= 2'd0;
      zext_q    <= 1'b0;
      addr_q    <= '0;
      st_data   <= 32'd0;
      data_buf  <= 32'd0;
      cap_en_q  <= 1'b0;
      cap_idx_q <= 2'd0;
`ifdef MISALIGN_TRAP_EN
      err_q     <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cap_en_q  <= (state_q == XFER) && !we_q;
      cap_idx_q <= idx_q;
      if (accept) begin
        we_q     <= req_we;
        size_q   <= req_size;
        zext_q   <= req_unsigned;
        addr_q   <= req_addr;
        st_data  <= req_wdata;
        last_q   <= 2'(size_bytes(req_size) - 3'd1);
        data_buf <= 32'd0;
`ifdef MISALIGN_TRAP_EN
        err_q    <= is_misaligned(req_size, req_addr[1:0]);
`endif
      end else if (cap_en_q) begin
        data_buf[{cap_idx_q, 3'b000} +: 8] <= mem_rdata;
      end
    end
  end

  ld_extend u_ld_extend (
    .data_in (data_buf),
    .size    (size_q),
    .zext    (zext_q),
    .rdata   (ext_data)
  );

endmodule

// File: tb/tb_mem_byte_seq.sv
// Scoreboard bench for mem_byte_seq: a request-level model predicts every byte
// access and the final response; a negedge monitor compares what the DUT does.
module tb_mem_byte_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [31:0] st_data;
  logic [1:0]  lane_sel;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_rdata = 8'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] rd_pending = 8'd0;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  lane;
    logic [7:0]  data;
  } acc_t;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } rsp_t;

  acc_t exp_acc[$];
  rsp_t exp_rsp[$];
  int   acc_cyc[$];
  logic [7:0] ref_mem [logic [31:0]];
  logic [7:0] bus_mem [logic [31:0]];

  mem_byte_seq #(.AW(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .st_data      (st_data),
    .lane_sel     (lane_sel),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  function automatic logic [7:0] init_byte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [7:0] bus_rd(input logic [31:0] a);
    return bus_mem.exists(a) ? bus_mem[a] : init_byte(a);
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Request-level reference: byte list, wrap-around addresses, arithmetic sign extension.
  task automatic model_request(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] addr, input logic [31:0] wdata);
    int n;
    logic [31:0] a, v, half, mask, val;
    acc_t e;
    rsp_t r;
    n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
`ifdef MISALIGN_TRAP_EN
    if ((size == 2'd1 && addr % 2 != 0) || (size == 2'd2 && addr % 4 != 0) || size == 2'd3) begin
      r.rdata = 32'd0; r.err = 1'b1; r.lat = 1;
      exp_rsp.push_back(r);
      return;
    end
`endif
    v = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + 32'(i);
      e.addr = a; e.we = we; e.lane = 2'(i);
      e.data = we ? 8'((wdata >> (8 * i)) & 32'hFF) : 8'h00;
      exp_acc.push_back(e);
      if (we) ref_mem[a] = e.data;
      else    v = v + (32'(ref_rd(a)) << (8 * i));
    end
    if (n == 4) val = v;
    else begin
      half = (n == 1) ? 32'd128 : 32'd32768;
      mask = 2 * half - 1;
      val  = v & mask;
      if (!uns && val >= half) val = val - 2 * half;
    end
    r.rdata = we ? 32'd0 : val;
    r.err   = 1'b0;
    r.lat   = we ? n + 1 : n + 2;
    exp_rsp.push_back(r);
  endtask

  task automatic apply_stimulus(input logic we, input logic [1:0] size, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                input bit hold, output int acc);
    int waited;
    waited = 0;
    acc = -1;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    model_request(we, size, uns, addr, wdata);
    while (!req_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) begin
      check_output("ready_timeout", 32'(req_ready), 32'd1);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    acc = cyc;
    acc_cyc.push_back(cyc);
    if (!hold) req_valid = 1'b0;
  endtask

  // Memory model plus the downstream 4:1 byte mux for stores.
  always @(posedge clk) begin
    #1;
    mem_rdata = rd_pending;
  end

  // Monitor: pops one expected access per mem_en cycle and one response per resp_valid.
  always @(negedge clk) begin
    acc_t e;
    rsp_t r;
    int a;
    if (rst_n) begin
      rd_pending = 8'($urandom);
      if (mem_en) begin
        if (mem_we) bus_mem[mem_addr] = st_data[8*lane_sel +: 8];
        else        rd_pending = bus_rd(mem_addr);
        if (exp_acc.size() == 0) check_output("unexpected_mem_en", 32'(mem_en), 32'd0);
        else begin
          e = exp_acc.pop_front();
          check_output("mem_addr", mem_addr, e.addr);
          check_output("mem_we", 32'(mem_we), 32'(e.we));
          check_output("lane_sel", 32'(lane_sel), 32'(e.lane));
          if (e.we) check_output("store_byte", 32'(st_data[8*lane_sel +: 8]), 32'(e.data));
        end
      end
      if (resp_valid) begin
        if (exp_rsp.size() == 0 || acc_cyc.size() == 0)
          check_output("unexpected_resp", 32'(resp_valid), 32'd0);
        else begin
          r = exp_rsp.pop_front();
          a = acc_cyc.pop_front();
          check_output("resp_rdata", resp_rdata, r.rdata);
          check_output("resp_err", 32'(resp_err), 32'(r.err));
          check_output("resp_latency", 32'(cyc - a + 1), 32'(r.lat));
          check_output("ready_in_done", 32'(req_ready), 32'd0);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int a1, a2, waited;
    logic [1:0] sz;
    logic [31:0] ad;

    #12;
    check_output("rst_req_ready", 32'(req_ready), 32'd0);
    check_output("rst_mem_en", 32'(mem_en), 32'd0);
    check_output("rst_mem_we", 32'(mem_we), 32'd0);
    check_output("rst_lane_sel", 32'(lane_sel), 32'd0);
    check_output("rst_mem_addr", mem_addr, 32'd0);
    check_output("rst_st_data", st_data, 32'd0);
    check_output("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_output("rst_resp_rdata", resp_rdata, 32'd0);
    check_output("rst_resp_err", 32'(resp_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("ready_after_reset", 32'(req_ready), 32'd1);

    // Directed cases
    apply_stimulus(1'b1, 2'd2, 1'b0, 32'h100, 32'hA1B2C3D4, 1'b0, a1);
    ref_mem[32'h203] = 8'h80;
    bus_mem[32'h203] = 8'h80;
    apply_stimulus(1'b0, 2'd0, 1'b0, 32'h203, 32'd0, 1'b0, a1);
    apply_stimulus(1'b0, 2'd0, 1'b1, 32'h203, 32'd0, 1'b0, a1);
    ref_mem[32'h10] = 8'h34; bus_mem[32'h10] = 8'h34;
    ref_mem[32'h11] = 8'h92; bus_mem[32'h11] = 8'h92;
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h10, 32'd0, 1'b0, a1);
    apply_stimulus(1'b0, 2'd2, 1'b0, 32'h2, 32'd0, 1'b0, a1);
    apply_stimulus(1'b0, 2'd3, 1'b1, 32'h100, 32'd0, 1'b0, a1);

    // Back-to-back at the top of the address space
    apply_stimulus(1'b1, 2'd0, 1'b0, 32'hFFFFFFFF, 32'h0000005C, 1'b1, a1);
    apply_stimulus(1'b0, 2'd0, 1'b1, 32'hFFFFFFFF, 32'd0, 1'b0, a2);
    check_output("b2b_accept_gap", 32'(a2 - a1), 32'd3);
    apply_stimulus(1'b0, 2'd2, 1'b0, 32'hFFFFFFFE, 32'd0, 1'b0, a1);

    // Randomized mix over a small overlapping window so loads see earlier stores
    for (int i = 0; i < 40; i++) begin
      sz = 2'($urandom_range(0, 3));
      ad = ($urandom_range(0, 7) == 0) ? 32'hFFFFFFFC + 32'($urandom_range(0, 3))
                                       : 32'h0F0 + 32'($urandom_range(0, 31));
      apply_stimulus(1'($urandom), sz, 1'($urandom), ad, $urandom, 1'($urandom_range(0, 3) == 0), a1);
    end
    @(negedge clk);
    req_valid = 1'b0;

    waited = 0;
    while ((exp_rsp.size() != 0 || exp_acc.size() != 0) && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    check_output("drain_rsp", 32'(exp_rsp.size()), 32'd0);
    check_output("drain_acc", 32'(exp_acc.size()), 32'd0);

    // Reset in the middle of a word store
    apply_stimulus(1'b1, 2'd2, 1'b0, 32'h700, 32'h11223344, 1'b0, a1);
    waited = 0;
    while (!(mem_en && lane_sel == 2'd1) && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    check_output("reached_idx1", 32'(lane_sel), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("abort_mem_en", 32'(mem_en), 32'd0);
    check_output("abort_resp_valid", 32'(resp_valid), 32'd0);
    check_output("abort_req_ready", 32'(req_ready), 32'd0);
    exp_acc.delete();
    exp_rsp.delete();
    acc_cyc.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("abort_ready_after", 32'(req_ready), 32'd1);
    check_output("abort_idle_mem_en", 32'(mem_en), 32'd0);
    apply_stimulus(1'b0, 2'd1, 1'b0, 32'h0F4, 32'd0, 1'b0, a1);
    repeat (6) @(negedge clk);
    check_output("final_drain", 32'(exp_rsp.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
